// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Sequencing controller for the stopwatch datapath. Turns debounced button
// pulses and mode switches into run/direction/load/clear controls, generates
// the count-enable tick, holds the countdown preset, strobes the leaderboard
// capture and times the beep request.
//
// Ports
//   clock_i        system clock
//   reset_i        asynchronous, active-high reset
//   start_stop_i   single-cycle pulse, start/pause/resume/leave DONE
//   increment_i    single-cycle pulse, preset increment (PROG only)
//   clear_i        single-cycle pulse, clear preset / stop / leave DONE
//   prog_i         level, program-preset mode
//   up_i           level, 1 = count up, 0 = count down
//   min_i          level, increment targets minutes (1) or seconds (0)
//   zero_i         stopwatch count equals zero
//   tick_o         one-cycle count enable while running
//   count_up_o     latched direction
//   load_o         one-cycle pulse, stopwatch loads the preset
//   clear_count_o  one-cycle pulse, stopwatch clears to 0
//   preset_min_o   preset minutes 0..99
//   preset_sec_o   preset seconds 0..59
//   record_o       one-cycle leaderboard capture strobe
//   expired_o      beep request level
//   state_o        FSM state code
//
// Optional feature: define STOPWATCH_AUTO_RELOAD_EN to reload the preset and
// keep running on countdown expiry instead of stopping in DONE.
//
// state | meaning
// IDLE  | stopped, waiting for start or program mode
// PROG  | editing the countdown preset
// RUN   | counting, tick active
// PAUSE | counting suspended, prescaler frozen
// DONE  | countdown expired, beep timed, waiting for acknowledge

module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned BEEP_MS = 500
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_stop_i,
  input  logic       increment_i,
  input  logic       clear_i,
  input  logic       prog_i,
  input  logic       up_i,
  input  logic       min_i,
  input  logic       zero_i,
  output logic       tick_o,
  output logic       count_up_o,
  output logic       load_o,
  output logic       clear_count_o,
  output logic [6:0] preset_min_o,
  output logic [5:0] preset_sec_o,
  output logic       record_o,
  output logic       expired_o,
  output logic [2:0] state_o
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW  = (BEEP_MS > 0) ? $clog2(BEEP_MS + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] BEEP_LOAD  = BW'(BEEP_MS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROG  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          count_up_q, count_up_d;
  logic          tick_q, tick_d;
  logic          load_q, load_d;
  logic          clear_count_q, clear_count_d;
  logic          record_q, record_d;
  logic          expired_q, expired_d;
  logic [6:0]    pmin_q, pmin_d;
  logic [5:0]    psec_q, psec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] beep_q, beep_d;

  logic presc_wrap;
  logic preset_nz;
  logic expire_hit;
  logic presc_run;

  assign presc_wrap = (presc_q == PRESC_LAST);
  assign preset_nz  = (pmin_q != 7'd0) || (psec_q != 6'd0);
  assign expire_hit = !count_up_q && zero_i;

  always_comb begin
    state_d       = state_q;
    count_up_d    = count_up_q;
    tick_d        = 1'b0;
    load_d        = 1'b0;
    clear_count_d = 1'b0;
    record_d      = 1'b0;
    expired_d     = expired_q;
    pmin_d        = pmin_q;
    psec_d        = psec_q;
    presc_d       = presc_q;
    beep_d        = beep_q;
    presc_run     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (prog_i) begin
          state_d = S_PROG;
        end else if (start_stop_i) begin
          if (up_i) begin
            count_up_d    = 1'b1;
            clear_count_d = 1'b1;
            presc_d       = '0;
            state_d       = S_RUN;
          end else if (preset_nz) begin
            count_up_d = 1'b0;
            load_d     = 1'b1;
            presc_d    = '0;
            state_d    = S_RUN;
          end
        end
      end

      S_PROG: begin
        if (clear_i) begin
          pmin_d = 7'd0;
          psec_d = 6'd0;
        end else if (increment_i) begin
          // Fields wrap independently; seconds never carry into minutes.
          if (min_i) pmin_d = (pmin_q == 7'd99) ? 7'd0 : pmin_q + 7'd1;
          else       psec_d = (psec_q == 6'd59) ? 6'd0 : psec_q + 6'd1;
        end
        if (!prog_i) state_d = S_IDLE;
      end

      S_RUN: begin
        presc_run = 1'b1;
        if (clear_i) begin
          clear_count_d = 1'b1;
          expired_d     = 1'b0;
          presc_run     = 1'b0;
          state_d       = S_IDLE;
        end else if (expire_hit) begin
          record_d  = 1'b1;
          expired_d = 1'b1;
          beep_d    = BEEP_LOAD;
          presc_d   = '0;
          presc_run = 1'b0;
`ifdef STOPWATCH_AUTO_RELOAD_EN
          load_d    = 1'b1;
`else
          state_d   = S_DONE;
`endif
        end else if (start_stop_i) begin
          presc_run = 1'b0;
          state_d   = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (clear_i) begin
          clear_count_d = 1'b1;
          record_d      = count_up_q;
          expired_d     = 1'b0;
          state_d       = S_IDLE;
        end else if (start_stop_i) begin
          presc_d = '0;
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        // Prescaler keeps running only to time the beep.
        presc_run = expired_q;
        if (start_stop_i || clear_i) begin
          clear_count_d = 1'b1;
          expired_d     = 1'b0;
          presc_run     = 1'b0;
          state_d       = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (presc_run) begin
      presc_d = presc_wrap ? '0 : presc_q + 1'b1;
      tick_d  = presc_wrap && (state_q == S_RUN);
      if (expired_q && presc_wrap) begin
        if (beep_q <= BW'(1)) begin
          beep_d    = '0;
          expired_d = 1'b0;
        end else begin
          beep_d = beep_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      count_up_q    <= 1'b1;
      tick_q        <= 1'b0;
      load_q        <= 1'b0;
      clear_count_q <= 1'b0;
      record_q      <= 1'b0;
      expired_q     <= 1'b0;
      pmin_q        <= 7'd0;
      psec_q        <= 6'd0;
      presc_q       <= '0;
      beep_q        <= '0;
    end else begin
      state_q       <= state_d;
      count_up_q    <= count_up_d;
      tick_q        <= tick_d;
      load_q        <= load_d;
      clear_count_q <= clear_count_d;
      record_q      <= record_d;
      expired_q     <= expired_d;
      pmin_q        <= pmin_d;
      psec_q        <= psec_d;
      presc_q       <= presc_d;
      beep_q        <= beep_d;
    end
  end

  assign tick_o        = tick_q;
  assign count_up_o    = count_up_q;
  assign load_o        = load_q;
  assign clear_count_o = clear_count_q;
  assign record_o      = record_q;
  assign expired_o     = expired_q;
  assign preset_min_o  = pmin_q;
  assign preset_sec_o  = psec_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam int SS  = 0;
  localparam int INC = 1;
  localparam int CLR = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic ss = 1'b0, inc = 1'b0, clr = 1'b0, prog = 1'b0, up = 1'b1, mn = 1'b0, zero = 1'b0;
  logic tick_o, cu_o, load_o, clrc_o, rec_o, exp_o;
  logic [6:0] pmin_o;
  logic [5:0] psec_o;
  logic [2:0] st_o;

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .BEEP_MS(3)) dut (
    .clock_i(clk), .reset_i(rst), .start_stop_i(ss), .increment_i(inc), .clear_i(clr),
    .prog_i(prog), .up_i(up), .min_i(mn), .zero_i(zero),
    .tick_o(tick_o), .count_up_o(cu_o), .load_o(load_o), .clear_count_o(clrc_o),
    .preset_min_o(pmin_o), .preset_sec_o(psec_o), .record_o(rec_o),
    .expired_o(exp_o), .state_o(st_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  // Expected observable events: every cycle showing a pulse or a change of
  // any level output is one event with a full snapshot.
  typedef struct {
    int cyc; int st; bit cu; bit tk; bit ld; bit cl; bit rc; bit ex; int pm; int ps;
  } ev_t;

  ev_t exp_q[$];
  int  m_st = 0;
  bit  m_cu = 1'b1, m_ex = 1'b0;
  int  m_pm = 0, m_ps = 0;
  int  n_chk = 0, n_pass = 0;
  bit  mon_en = 1'b0;
  ev_t prev;

  function automatic void push(input int c, input bit tk, input bit ld, input bit cl, input bit rc);
    ev_t e;
    e.cyc = c; e.st = m_st; e.cu = m_cu; e.tk = tk; e.ld = ld; e.cl = cl; e.rc = rc;
    e.ex = m_ex; e.pm = m_pm; e.ps = m_ps;
    exp_q.push_back(e);
  endfunction

  function automatic string ev_str(input ev_t e);
    return $sformatf("cyc=%0d st=%0d cu=%0d tk=%0d ld=%0d cl=%0d rc=%0d ex=%0d pm=%0d ps=%0d",
                     e.cyc, e.st, e.cu, e.tk, e.ld, e.cl, e.rc, e.ex, e.pm, e.ps);
  endfunction

  function automatic bit ev_eq(input ev_t a, input ev_t b);
    return a.cyc == b.cyc && a.st == b.st && a.cu == b.cu && a.tk == b.tk && a.ld == b.ld &&
           a.cl == b.cl && a.rc == b.rc && a.ex == b.ex && a.pm == b.pm && a.ps == b.ps;
  endfunction

  always @(negedge clk) begin
    ev_t s, e;
    if (mon_en) begin
      s.cyc = cyc; s.st = int'(st_o); s.cu = cu_o; s.tk = tick_o; s.ld = load_o; s.cl = clrc_o;
      s.rc = rec_o; s.ex = exp_o; s.pm = int'(pmin_o); s.ps = int'(psec_o);
      if (s.tk || s.ld || s.cl || s.rc || s.st != prev.st || s.cu != prev.cu ||
          s.ex != prev.ex || s.pm != prev.pm || s.ps != prev.ps) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: got %s, required none", ev_str(s));
        end else begin
          e = exp_q.pop_front();
          if (ev_eq(s, e)) n_pass++;
          else $display("FAIL event: got %s, required %s", ev_str(s), ev_str(e));
        end
      end
      prev = s;
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, expv);
  endtask

  task automatic at(input int c);
    if (cyc > c) $display("note: schedule slipped to %0d (wanted %0d)", cyc, c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input int c, input int which);
    at(c);
    case (which)
      SS:      ss  = 1'b1;
      INC:     inc = 1'b1;
      default: clr = 1'b1;
    endcase
    @(negedge clk);
    ss = 1'b0; inc = 1'b0; clr = 1'b0;
  endtask

  task automatic push_ticks(input int from, input int len);
    for (int k = 1; 10 * k < len; k++) push(from + 10 * k, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int pick(input int lo, input int hi);
    int v;
    v = int'($urandom_range(hi, lo));
    if (v % 10 == 0) v = v + 1;
    return v;
  endfunction

  initial begin
    int t, r, r2, q, l, l2, p, n, x, y;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", int'(st_o), 0);
    chk("rst_count_up", int'(cu_o), 1);
    chk("rst_tick", int'(tick_o), 0);
    chk("rst_pulses", int'({load_o, clrc_o, rec_o}), 0);
    chk("rst_expired", int'(exp_o), 0);
    chk("rst_preset", int'({pmin_o, psec_o}), 0);
    rst = 1'b0;
    prev.st = 0; prev.cu = 1'b1; prev.ex = 1'b0; prev.pm = 0; prev.ps = 0;
    mon_en = 1'b1;

    // Count up: clear_count on start, ticks every 10 cycles, clear in RUN without record.
    t = cyc + 2; r = t + 1; l = pick(25, 75);
    m_st = 2; m_cu = 1'b1; push(r, 1'b0, 1'b0, 1'b1, 1'b0);
    push_ticks(r, l);
    m_st = 0; push(r + l, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(t, SS); pulse(r + l - 1, CLR);

    // Preset programming with wraps, ignored start_stop, clear.
    t = cyc + 2; m_st = 1; push(t + 1, 1'b0, 1'b0, 1'b0, 1'b0);
    at(t); prog = 1'b1; mn = 1'b0;
    t = t + 3; pulse(t, SS); t = t + 3;
    for (int i = 0; i < 61; i++) begin
      m_ps = (m_ps + 1) % 60; push(t + 1, 1'b0, 1'b0, 1'b0, 1'b0);
      pulse(t, INC); t = t + 2 + int'($urandom_range(2, 0));
    end
    at(t); mn = 1'b1; t = t + 2;
    for (int i = 0; i < 101; i++) begin
      m_pm = (m_pm + 1) % 100; push(t + 1, 1'b0, 1'b0, 1'b0, 1'b0);
      pulse(t, INC); t = t + 2 + int'($urandom_range(2, 0));
    end
    at(t);
    chk("preset_sec_wrap", int'(psec_o), 1);
    chk("preset_min_wrap", int'(pmin_o), 1);
    m_pm = 0; m_ps = 0; push(t + 1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(t, CLR); t = t + 3;
    m_st = 0; push(t + 1, 1'b0, 1'b0, 1'b0, 1'b0);
    at(t); prog = 1'b0;

    // Countdown with zero preset is ignored.
    t = cyc + 2; at(t); up = 1'b0; t = t + 2;
    pulse(t, SS); at(t + 4);
    chk("zero_preset_state", int'(st_o), m_st);
    chk("zero_preset_count_up", int'(cu_o), int'(m_cu));

    // Random non-zero preset, countdown to expiry.
    t = cyc + 2; m_st = 1; push(t + 1, 1'b0, 1'b0, 1'b0, 1'b0);
    at(t); prog = 1'b1; mn = 1'b0; t = t + 3;
    n = int'($urandom_range(9, 3));
    for (int i = 0; i < n; i++) begin
      m_ps = (m_ps + 1) % 60; push(t + 1, 1'b0, 1'b0, 1'b0, 1'b0);
      pulse(t, INC); t = t + 2 + int'($urandom_range(2, 0));
    end
    at(t); mn = 1'b1; t = t + 2;
    n = int'($urandom_range(2, 0));
    for (int i = 0; i < n; i++) begin
      m_pm = (m_pm + 1) % 100; push(t + 1, 1'b0, 1'b0, 1'b0, 1'b0);
      pulse(t, INC); t = t + 2;
    end
    m_st = 0; push(t + 1, 1'b0, 1'b0, 1'b0, 1'b0);
    at(t); prog = 1'b0;
    t = t + 3; r = t + 1; l = pick(15, 45); r2 = r + l;
    m_st = 2; m_cu = 1'b0; push(r, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ticks(r, l);
`ifdef STOPWATCH_AUTO_RELOAD_EN
    m_ex = 1'b1; push(r2, 1'b0, 1'b1, 1'b0, 1'b1);
    push(r2 + 10, 1'b1, 1'b0, 1'b0, 1'b0);
    push(r2 + 20, 1'b1, 1'b0, 1'b0, 1'b0);
    m_ex = 1'b0; push(r2 + 30, 1'b1, 1'b0, 1'b0, 1'b0);
    m_st = 0; push(r2 + 35, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(t, SS); at(r + 3); up = 1'b1;
    at(r2 - 1); zero = 1'b1; @(negedge clk); zero = 1'b0;
    at(r2 + 2); up = 1'b0;
    pulse(r2 + 34, CLR);
`else
    m_st = 4; m_ex = 1'b1; push(r2, 1'b0, 1'b0, 1'b0, 1'b1);
    m_ex = 1'b0; push(r2 + 30, 1'b0, 1'b0, 1'b0, 1'b0);
    x = int'($urandom_range(20, 2));
    m_st = 0; push(r2 + 30 + x, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(t, SS); at(r + 3); up = 1'b1;
    at(r2 - 1); zero = 1'b1; @(negedge clk); zero = 1'b0;
    at(r2 + 2); up = 1'b0;
    at(r2 + 12);
    chk("done_state", int'(st_o), 4);
    chk("done_expired", int'(exp_o), 1);
    at(r2 + 31);
    chk("done_after_beep_state", int'(st_o), 4);
    chk("done_after_beep_expired", int'(exp_o), 0);
    pulse(r2 + 29 + x, ($urandom_range(1, 0) == 0) ? SS : CLR);
`endif

    // Pause/resume, then clear in PAUSE of an up count records.
    up = 1'b1;
    t = cyc + 2; r = t + 1; l = pick(12, 38);
    m_st = 2; m_cu = 1'b1; push(r, 1'b0, 1'b0, 1'b1, 1'b0);
    push_ticks(r, l);
    m_st = 3; push(r + l, 1'b0, 1'b0, 1'b0, 1'b0);
    p = 50 + int'($urandom_range(10, 0)); q = r + l + p;
    m_st = 2; push(q, 1'b0, 1'b0, 1'b0, 1'b0);
    l2 = pick(12, 38); push_ticks(q, l2);
    m_st = 3; push(q + l2, 1'b0, 1'b0, 1'b0, 1'b0);
    y = int'($urandom_range(8, 3));
    m_st = 0; push(q + l2 + y, 1'b0, 1'b0, 1'b1, 1'b1);
    pulse(t, SS); pulse(r + l - 1, SS);
    at(r + l + 5); up = 1'b0;
    pulse(q - 1, SS); pulse(q + l2 - 1, SS); pulse(q + l2 + y - 1, CLR);

    // Countdown paused then cleared: no record.
    t = cyc + 2; r = t + 1; l = pick(12, 25);
    m_st = 2; m_cu = 1'b0; push(r, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ticks(r, l);
    m_st = 3; push(r + l, 1'b0, 1'b0, 1'b0, 1'b0);
    m_st = 0; push(r + l + 4, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(t, SS); pulse(r + l - 1, SS); pulse(r + l + 3, CLR);

    // zero and start_stop in the same cycle: expiry wins.
    t = cyc + 2; r = t + 1; l = pick(5, 25); r2 = r + l;
    m_st = 2; m_cu = 1'b0; push(r, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ticks(r, l);
`ifdef STOPWATCH_AUTO_RELOAD_EN
    m_ex = 1'b1; push(r2, 1'b0, 1'b1, 1'b0, 1'b1);
    y = 5;
`else
    m_st = 4; m_ex = 1'b1; push(r2, 1'b0, 1'b0, 1'b0, 1'b1);
    y = int'($urandom_range(25, 3));
`endif
    m_st = 0; m_ex = 1'b0; push(r2 + y, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(t, SS);
    at(r2 - 1); ss = 1'b1; zero = 1'b1; @(negedge clk); ss = 1'b0; zero = 1'b0;
    pulse(r2 + y - 1, CLR);

    // Asynchronous reset in the middle of RUN.
    up = 1'b1;
    t = cyc + 2; r = t + 1; l = pick(13, 18);
    m_st = 2; m_cu = 1'b1; push(r, 1'b0, 1'b0, 1'b1, 1'b0);
    push(r + 10, 1'b1, 1'b0, 1'b0, 1'b0);
    m_st = 0; m_cu = 1'b1; m_ex = 1'b0; m_pm = 0; m_ps = 0;
    push(r + l, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(t, SS);
    at(r + l - 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_state", int'(st_o), 0);
    chk("async_rst_tick", int'(tick_o), 0);
    chk("async_rst_record", int'(rec_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    repeat (5) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL leftover_events: got %0d outstanding, required 0 (next %s)",
                  exp_q.size(), ev_str(exp_q[0]));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
